fir_coef_sched: RTL and testbench
=================================

// Module: fir_coef_sched
// PURPOSE
// Coefficient-bank controller for FIR_NORM. Accepts coefficients over a valid/ready stream
// into a shadow bank, then swaps shadow->active atomically on a sample boundary so the
// filter never sees a half-written set. Drives FIR_NORM's flat coefs port directly.
// PARAMETERS
// TAPS  64  number of filter taps (>=2)
// CW    16  coefficient width, signed
// PORTS
// clk         in   1        system clock, rising edge
// rst         in   1        synchronous reset, active-high
// load_start  in   1        1-cycle pulse: begin loading a new coefficient set
// cin_valid   in   1        coefficient word valid
// cin_ready   out  1        block accepts a word this cycle
// cin_data    in   CW       coefficient word; first accepted = tap 0
// commit      in   1        1-cycle pulse: arm loaded set for swap
// sample_en   in   1        sample strobe, same cycle FIR_NORM takes a new input
// coefs       out  TAPS*CW  active bank; tap k at [k*CW +: CW], registered
// busy        out  1        state != IDLE
// armed       out  1        state == ARMED
// swap_done   out  1        1-cycle pulse, registered, on the edge that updates coefs
// err_short   out  1        sticky: commit received with fewer than TAPS words
// BEHAVIOUR
// - Reset: state IDLE, idx=0, shadow and active banks all zero, coefs=0, cin_ready=0,
//   armed=0, busy=0, swap_done=0, err_short=0. Reset mid-load discards shadow contents.
// - States IDLE, LOAD, FULL, ARMED. cin_ready = (state==LOAD), registered.
// - IDLE: load_start -> LOAD, idx=0, err_short cleared. commit/cin_valid ignored.
// - LOAD: cin_valid&cin_ready writes shadow[idx], idx++. Edge accepting word TAPS-1 ->
//   FULL, so cin_ready is low from the next cycle; no extra word is ever accepted.
//   commit in LOAD (idx<TAPS) -> err_short=1, state IDLE, active bank untouched.
//   load_start in LOAD -> restart, idx=0 (words already written are overwritten).
// - FULL: commit -> ARMED. load_start -> LOAD, idx=0. Waits indefinitely otherwise.
// - ARMED: on edge with sample_en=1: active<=shadow (all taps same edge), swap_done=1,
//   state IDLE. If load_start in that same cycle: swap still happens, state -> LOAD, idx=0.
//   load_start without sample_en in ARMED: cancel arm, state LOAD, idx=0, no swap.
// - commit and load_start in same cycle: load_start wins in every state.
// - Swap latency: coefs shows new set the cycle after the sample_en edge; FIR_NORM uses
//   it for the sample after the one presented with sample_en.
// - idx width $clog2(TAPS+1); never wraps, saturates state to FULL at TAPS.
// - Shadow content held across IDLE; only a completed commit+swap touches active bank.
// - No arithmetic on data; coefficient words passed bit-exact, sign preserved.
// TESTING
// 1 Reset -> coefs=0, cin_ready=0, busy=0; hold 5 cycles with cin_valid=1: nothing taken.
// 2 load_start, stream TAPS words k+1 (k=0..63) with valid always high -> exactly 64
//   accepted, cin_ready low after 64th; commit; sample_en -> swap_done 1 cycle,
//   coefs[k*16+:16]==k+1 next cycle.
// 3 Load 10 words then commit -> err_short=1, state IDLE, coefs unchanged from test 2.
// 4 Random cin_valid gaps (50%) and sample_en every 7 cycles during LOAD/FULL ->
//   coefs never changes before ARMED+sample_en; final bank matches stream order.
// 5 ARMED with sample_en and load_start same cycle -> swap_done=1, coefs updated,
//   state LOAD, idx=0; ARMED with load_start only -> no swap, coefs unchanged.
// 6 Assert rst mid-LOAD after 30 words -> all outputs to reset values; subsequent full
//   load+commit+swap produces new set with no residue from aborted load.

Source files
------------

// File: rtl/fir_coef_sched.sv
// Coefficient-bank controller for FIR_NORM: streams a coefficient set into a
// shadow bank, then copies it to the active bank on a sample boundary so the
// filter only ever sees a complete set.
module fir_coef_sched #(
    parameter int unsigned TAPS = 64,
    parameter int unsigned CW   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_start,
    input  logic                 cin_valid,
    output logic                 cin_ready,
    input  logic [CW-1:0]        cin_data,
    input  logic                 commit,
    input  logic                 sample_en,
    output logic [TAPS*CW-1:0]   coefs,
    output logic                 busy,
    output logic                 armed,
    output logic                 swap_done,
    output logic                 err_short
);

    localparam int unsigned IW = $clog2(TAPS + 1);
    localparam int unsigned AW = $clog2(TAPS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_FULL  = 2'd2,
        S_ARMED = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                err_short_q, err_short_d;
    logic                cin_ready_q;
    logic                busy_q;
    logic                armed_q;
    logic                swap_done_q;
    logic                wr_en;
    logic                swap;
    logic [AW-1:0]       wr_addr;
    logic [CW-1:0]       shadow_q [TAPS];
    logic [TAPS*CW-1:0]  coefs_q;

    assign wr_addr = idx_q[AW-1:0];

    // Next-state, index and strobe decode; load_start always outranks commit.
    // A word offered alongside load_start or commit in LOAD is not written.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_short_d = err_short_q;
        wr_en       = 1'b0;
        swap        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load_start) begin
                    state_d     = S_LOAD;
                    idx_d       = '0;
                    err_short_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (load_start) begin
                    idx_d = '0;
                end else if (commit) begin
                    state_d     = S_IDLE;
                    idx_d       = '0;
                    err_short_d = 1'b1;
                end else if (cin_valid && cin_ready_q) begin
                    wr_en = 1'b1;
                    if (idx_q == IW'(TAPS - 1)) begin
                        state_d = S_FULL;
                        idx_d   = IW'(TAPS);
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_FULL: begin
                if (load_start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end else if (commit) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (sample_en) begin
                    swap = 1'b1;
                    if (load_start) begin
                        state_d = S_LOAD;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (load_start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Control state and registered status outputs, derived from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            err_short_q <= 1'b0;
            cin_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            armed_q     <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_short_q <= err_short_d;
            cin_ready_q <= (state_d == S_LOAD);
            busy_q      <= (state_d != S_IDLE);
            armed_q     <= (state_d == S_ARMED);
            swap_done_q <= swap;
        end
    end

    // Shadow bank: one word per accepted handshake, held until overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(TAPS); k++) begin
                shadow_q[k] <= '0;
            end
        end else if (wr_en) begin
            shadow_q[wr_addr] <= cin_data;
        end
    end

    // Active bank: all taps replaced on the same edge as the swap.
    always_ff @(posedge clk) begin
        if (rst) begin
            coefs_q <= '0;
        end else if (swap) begin
            for (int k = 0; k < int'(TAPS); k++) begin
                coefs_q[k*CW +: CW] <= shadow_q[k];
            end
        end
    end

    assign cin_ready = cin_ready_q;
    assign busy      = busy_q;
    assign armed     = armed_q;
    assign swap_done = swap_done_q;
    assign err_short = err_short_q;
    assign coefs     = coefs_q;

endmodule

// File: tb/tb_fir_coef_sched.sv
// Self-checking bench for fir_coef_sched: a bench-side shadow model feeds a
// queue of expected banks on commit, popped and compared on swap_done.
module tb_fir_coef_sched;

    localparam int unsigned TAPS = 64;
    localparam int unsigned CW   = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                load_start;
    logic                cin_valid;
    logic                cin_ready;
    logic [CW-1:0]       cin_data;
    logic                commit;
    logic                sample_en;
    logic [TAPS*CW-1:0]  coefs;
    logic                busy;
    logic                armed;
    logic                swap_done;
    logic                err_short;

    fir_coef_sched #(.TAPS(TAPS), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .cin_valid  (cin_valid),
        .cin_ready  (cin_ready),
        .cin_data   (cin_data),
        .commit     (commit),
        .sample_en  (sample_en),
        .coefs      (coefs),
        .busy       (busy),
        .armed      (armed),
        .swap_done  (swap_done),
        .err_short  (err_short)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [CW-1:0]      stim     [TAPS];
    logic [CW-1:0]      m_shadow [TAPS];
    logic [TAPS*CW-1:0] exp_active;
    logic [TAPS*CW-1:0] exp_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TAPS*CW-1:0] pack_shadow();
        logic [TAPS*CW-1:0] v;
        for (int k = 0; k < int'(TAPS); k++) v[k*CW +: CW] = m_shadow[k];
        return v;
    endfunction

    function automatic int first_diff(input logic [TAPS*CW-1:0] a, input logic [TAPS*CW-1:0] b);
        for (int k = 0; k < int'(TAPS); k++) if (a[k*CW +: CW] !== b[k*CW +: CW]) return k;
        return 0;
    endfunction

    // Stream stim[0..n-1]; optional valid gaps and sample_en every 7 cycles;
    // active bank must hold still throughout.
    task automatic stream(input string name, input int n, input bit gaps, input bit strobe);
        int got = 0;
        int cyc = 0;
        int d;
        while (got < n && cyc < 1000) begin
            cin_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            cin_data  = stim[got];
            sample_en = strobe && (cyc % 7 == 6);
            if (cin_valid && cin_ready) begin
                m_shadow[got] = stim[got];
                got++;
            end
            step();
            cyc++;
            if (strobe) begin
                checks++;
                if (coefs !== exp_active || swap_done !== 1'b0) begin
                    d = first_diff(coefs, exp_active);
                    $display("FAIL %s_quiet cyc=%0d swap_done=%b tap%0d got %h exp %h", name, cyc,
                             swap_done, d, coefs[d*CW +: CW], exp_active[d*CW +: CW]);
                end else passed++;
            end
        end
        cin_valid = 1'b0;
        sample_en = 1'b0;
        checks++;
        if (got !== n) $display("FAIL %s_accept got %0d words exp %0d within budget", name, got, n);
        else passed++;
    endtask

    task automatic do_load_start();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    // Commit a complete set and expect ARMED; the set is queued for the swap.
    task automatic do_commit(input string name);
        commit = 1'b1;
        exp_q.push_back(pack_shadow());
        step();
        commit = 1'b0;
        checks++;
        if (armed !== 1'b1 || busy !== 1'b1 || cin_ready !== 1'b0)
            $display("FAIL %s_armed armed=%b busy=%b cin_ready=%b exp 1 1 0", name, armed, busy, cin_ready);
        else passed++;
    endtask

    // Called #1 after the swap edge: pulse and new bank must be visible.
    task automatic score_swap(input string name);
        logic [TAPS*CW-1:0] e;
        int d;
        checks++;
        if (swap_done !== 1'b1) $display("FAIL %s_swap_done got %b exp 1", name, swap_done);
        else passed++;
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s_scoreboard empty at swap", name);
        end else begin
            e = exp_q.pop_front();
            exp_active = e;
            if (coefs !== e) begin
                d = first_diff(coefs, e);
                $display("FAIL %s_coefs tap%0d got %h exp %h", name, d, coefs[d*CW +: CW], e[d*CW +: CW]);
            end else passed++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; load_start = 1'b0; cin_valid = 1'b0; cin_data = '0; commit = 1'b0; sample_en = 1'b0;
        for (int k = 0; k < int'(TAPS); k++) m_shadow[k] = '0;
        exp_active = '0;
        step(); step();
        rst = 1'b0;
        cin_valid = 1'b1;
        cin_data  = 16'h5A5A;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (coefs !== '0 || cin_ready !== 1'b0 || busy !== 1'b0 || armed !== 1'b0 ||
                swap_done !== 1'b0 || err_short !== 1'b0)
                $display("FAIL reset_idle c=%0d coefs_nz=%b rdy=%b busy=%b armed=%b swap=%b err=%b exp all 0",
                         c, (coefs != '0), cin_ready, busy, armed, swap_done, err_short);
            else passed++;
        end
        cin_valid = 1'b0;
    endtask

    task automatic test_full_load();
        for (int k = 0; k < int'(TAPS); k++) stim[k] = CW'(k + 1);
        do_load_start();
        checks++;
        if (cin_ready !== 1'b1 || busy !== 1'b1) $display("FAIL full_enter rdy=%b busy=%b exp 1 1", cin_ready, busy);
        else passed++;
        stream("full", TAPS, 1'b0, 1'b0);
        checks++;
        if (cin_ready !== 1'b0) $display("FAIL full_ready_low got %b exp 0", cin_ready);
        else passed++;
        cin_valid = 1'b1;
        cin_data  = 16'hDEAD;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (cin_ready !== 1'b0) $display("FAIL full_no_extra c=%0d cin_ready=%b exp 0", c, cin_ready);
            else passed++;
        end
        cin_valid = 1'b0;
        do_commit("full");
        sample_en = 1'b1;
        step();
        sample_en = 1'b0;
        score_swap("full");
        step();
        checks++;
        if (swap_done !== 1'b0 || busy !== 1'b0 || armed !== 1'b0)
            $display("FAIL full_after swap=%b busy=%b armed=%b exp 0 0 0", swap_done, busy, armed);
        else passed++;
    endtask

    task automatic test_short();
        for (int k = 0; k < int'(TAPS); k++) stim[k] = CW'(16'h7000 + k);
        do_load_start();
        stream("short", 10, 1'b0, 1'b0);
        commit = 1'b1;
        step();
        commit = 1'b0;
        checks++;
        if (err_short !== 1'b1 || busy !== 1'b0 || cin_ready !== 1'b0 || armed !== 1'b0)
            $display("FAIL short_err err=%b busy=%b rdy=%b armed=%b exp 1 0 0 0", err_short, busy, cin_ready, armed);
        else passed++;
        step(); step();
        checks++;
        if (coefs !== exp_active || err_short !== 1'b1)
            $display("FAIL short_hold coefs_changed=%b err=%b exp 0 1", (coefs !== exp_active), err_short);
        else passed++;
    endtask

    task automatic test_random_gaps();
        for (int k = 0; k < int'(TAPS); k++) stim[k] = CW'($urandom);
        do_load_start();
        checks++;
        if (err_short !== 1'b0) $display("FAIL gaps_err_clear got %b exp 0", err_short);
        else passed++;
        stream("gaps", TAPS, 1'b1, 1'b1);
        for (int c = 0; c < 14; c++) begin
            sample_en = (c % 7 == 0);
            step();
            checks++;
            if (coefs !== exp_active || swap_done !== 1'b0)
                $display("FAIL gaps_full_hold c=%0d changed=%b swap=%b exp 0 0", c, (coefs !== exp_active), swap_done);
            else passed++;
        end
        sample_en = 1'b0;
        do_commit("gaps");
        step(); step();
        checks++;
        if (coefs !== exp_active || armed !== 1'b1)
            $display("FAIL gaps_armed_hold changed=%b armed=%b exp 0 1", (coefs !== exp_active), armed);
        else passed++;
        sample_en = 1'b1;
        step();
        sample_en = 1'b0;
        score_swap("gaps");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < int'(TAPS); k++) stim[k] = CW'(16'h8000 + 3 * k);
        do_load_start();
        stream("b2b_a", TAPS, 1'b0, 1'b0);
        do_commit("b2b_a");
        sample_en  = 1'b1;
        load_start = 1'b1;
        step();
        sample_en  = 1'b0;
        load_start = 1'b0;
        score_swap("b2b_a");
        checks++;
        if (cin_ready !== 1'b1 || busy !== 1'b1 || armed !== 1'b0)
            $display("FAIL b2b_reload rdy=%b busy=%b armed=%b exp 1 1 0", cin_ready, busy, armed);
        else passed++;
        for (int k = 0; k < int'(TAPS); k++) stim[k] = CW'(16'hF000 - 7 * k);
        stream("b2b_b", TAPS, 1'b0, 1'b0);
        do_commit("b2b_b");
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        void'(exp_q.pop_back());
        checks++;
        if (swap_done !== 1'b0 || armed !== 1'b0 || cin_ready !== 1'b1 || coefs !== exp_active)
            $display("FAIL b2b_cancel swap=%b armed=%b rdy=%b changed=%b exp 0 0 1 0",
                     swap_done, armed, cin_ready, (coefs !== exp_active));
        else passed++;
        for (int k = 0; k < int'(TAPS); k++) stim[k] = CW'(16'h1234 ^ (k << 8));
        stream("b2b_c", TAPS, 1'b0, 1'b0);
        do_commit("b2b_c");
        sample_en = 1'b1;
        step();
        sample_en = 1'b0;
        score_swap("b2b_c");
    endtask

    task automatic test_reset_mid_load();
        for (int k = 0; k < int'(TAPS); k++) stim[k] = CW'(16'hAAAA);
        do_load_start();
        stream("rst_part", 30, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < int'(TAPS); k++) m_shadow[k] = '0;
        exp_active = '0;
        exp_q.delete();
        checks++;
        if (coefs !== '0 || cin_ready !== 1'b0 || busy !== 1'b0 || armed !== 1'b0 ||
            swap_done !== 1'b0 || err_short !== 1'b0)
            $display("FAIL rst_mid coefs_nz=%b rdy=%b busy=%b armed=%b swap=%b err=%b exp all 0",
                     (coefs != '0), cin_ready, busy, armed, swap_done, err_short);
        else passed++;
        for (int k = 0; k < int'(TAPS); k++) stim[k] = CW'(5 * k + 7);
        do_load_start();
        stream("rst_full", TAPS, 1'b0, 1'b0);
        do_commit("rst_full");
        sample_en = 1'b1;
        step();
        sample_en = 1'b0;
        score_swap("rst_full");
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_short();
        test_random_gaps();
        test_back_to_back();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
